pwm_output_stage: RTL and testbench
===================================

# pwm_output_stage

Registered output conditioner between `pwm_driver` and the LED pins. It applies the MODE2 polarity and drive-mode controls, the sleep state and the external active-low output-enable pin to the 16 raw PWM levels. It produces the pin data and per-pin drive-enable for the pad tri-states. Configuration changes are applied at PWM period boundaries so that no pin ever sees a runt pulse.

## Interface

Parameters:
- `CHANNELS`, default 16: number of PWM channels.
- `SYNC_STAGES`, default 2: flop count of the `oe_ni` synchronizer; legal range ≥2.

Ports:
- `clk_i`  in  1: system clock.
- `rst_ni`  in  1: reset. One clock; reset is asynchronous and active-low.
- `counter_i`  in  12: prescaled PWM counter (0..4095).
- `pwm_i`  in  CHANNELS: raw channel levels from `pwm_driver`, bit n = channel n.
- `mode2_i`  in  8: MODE2 register. Fields:
  - [4] INVRT
  - [2] OUTDRV (1 = totem-pole, 0 = open-drain)
  - [1:0] OUTNE
  - other bits ignored.
- `sleep_i`  in  1: MODE1[4] SLEEP.
- `oe_ni`  in  1: external output-enable pin, asynchronous, active-low.
- `pwm_o`  out  CHANNELS: pin data.
- `pwm_oe_o`  out  CHANNELS: pin drive enable (1 = drive `pwm_o`, 0 = high-Z).
- `period_start_o`  out  1: one-cycle pulse per detected period boundary.
- `active_o`  out  1: 1 when the applied config is awake and the synced OE is asserted.

## Operation

**Boundary detection**
- `prev_q` holds the previous `counter_i` value; reset value 0.
- Boundary = (`counter_i` == 0) && (`prev_q` != 0).
- A counter held at 0 across several clocks yields one boundary only.

**Applied config**
- Registers `invrt_q`, `outdrv_q`, `outne_q`, `sleep_q`.
- Reset values: 0, 1, 00, 1.
- SLEEP 0→1 applies on the next clock.
- All other changes apply in the boundary cycle.
- While `sleep_q` = 1, MODE2 fields also apply on the next clock.

**OE synchronizer**
- `oe_ni` passes through `SYNC_STAGES` flops, each with reset value 1 (disabled).
- Output of the last flop = `oe_sync`.

**Per-channel output function**, registered:
- `lvl` = (`sleep_q` ? 0 : `pwm_i[n]`) ^ `invrt_q`.
- If `oe_sync` = 0 (enabled):
  - OUTDRV = 1 → `pwm_o` = `lvl`, `pwm_oe_o` = 1.
  - OUTDRV = 0 → `pwm_o` = 0, `pwm_oe_o` = ~`lvl`.
- If `oe_sync` = 1 (disabled), selected by OUTNE:
  - 00 → `pwm_o` = 0, `pwm_oe_o` = 1.
  - 01 → `pwm_o` = 1, `pwm_oe_o` = `outdrv_q`; open-drain cannot drive 1, so the pin floats.
  - 1x → `pwm_o` = 0, `pwm_oe_o` = 0.

**Other outputs**
- `active_o` = ~`sleep_q` & ~`oe_sync`, registered.

## Timing

**Reset values**
- `pwm_o` = 0, `pwm_oe_o` = 0, `period_start_o` = 0, `active_o` = 0.
- Reset applies mid-period at any time, asynchronously.
- After reset deassertion, the first boundary may only occur after `counter_i` has been nonzero for at least one clock.

**Latencies**
- `pwm_i` → `pwm_o`/`pwm_oe_o`: 1 clock.
- `oe_ni` edge → outputs: `SYNC_STAGES`+1 clocks.
- SLEEP set → outputs off: 2 clocks.
- SLEEP clear or MODE2 change while awake: outputs reflect the new config 1 clock after the boundary cycle.
- `period_start_o`: registered; high the clock after the boundary cycle.

**Simultaneous events**
- SLEEP clear and a MODE2 change pending at the same boundary: both apply together.
- SLEEP set and a boundary in the same cycle: the sleep applies; MODE2 is also captured.
- `oe_ni` change in the boundary cycle: independent of the boundary, no interaction.

## Configuration

`PWM_OUTPUT_STAGE_BOUNDARY_LATCH_EN`:
- Defined: boundary-aligned application of MODE2 and SLEEP-clear, exactly as above.
- Undefined: all applied-config registers load `mode2_i`/`sleep_i` every clock, giving 2-clock config latency. Boundary detection and `period_start_o` remain.

## Test plan

- **Reset:** reset asserted with `pwm_i` = 16'hFFFF.
  - Expect `pwm_o` = 0, `pwm_oe_o` = 0, `active_o` = 0.
  - After release, with `sleep_i` = 0, `oe_ni` = 0, counter running: outputs follow `pwm_i` 1 clock after the first boundary.
- **Boundary-aligned INVRT:** set INVRT while the counter is at 2000, `pwm_i[3]` = 1.
  - `pwm_o[3]` stays 1 until 1 clock after `counter_i` returns to 0, then becomes 0.
  - With the macro undefined, `pwm_o[3]` becomes 0 2 clocks after the write.
- **Open-drain:** MODE2 = 8'h00, `pwm_i[0]` toggling.
  - `pwm_o[0]` is constantly 0; `pwm_oe_o[0]` = ~`pwm_i[0]` delayed 1 clock.
- **OE pin, each OUTNE value:** pulse `oe_ni` high.
  - 3 clocks later (`SYNC_STAGES` = 2), all channels show 0/1 per OUTNE=00/01, or `pwm_oe_o` = 0 for OUTNE=1x.
  - Outputs recover 3 clocks after `oe_ni` falls.
- **Sleep:** assert `sleep_i` mid-period.
  - Outputs go to the off level and `active_o` = 0 within 2 clocks.
  - Deassert `sleep_i` at counter 100: outputs resume only after the next wrap.
  - `period_start_o` pulses exactly once per wrap, including when the counter is held at 0 for 5 clocks.

Source files
------------

// File: rtl/pwm_output_stage.sv
// pwm_output_stage: registered output conditioner between pwm_driver and the LED pads.
// Applies MODE2 polarity and drive mode, SLEEP and the external OE pin to the raw
// PWM levels. Configuration changes take effect at PWM period boundaries so that
// no pin ever sees a runt pulse.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   counter_i  [11:0]    prescaled PWM counter; counter wrap to 0 marks a period boundary
//   pwm_i      [CH-1:0]  raw channel levels
//   mode2_i    [7:0]     MODE2: [4] INVRT, [2] OUTDRV, [1:0] OUTNE
//   sleep_i              MODE1 SLEEP
//   oe_ni                external output-enable pin (async, active-low)
//   pwm_o      [CH-1:0]  pin data
//   pwm_oe_o   [CH-1:0]  pin drive enable (1 = drive, 0 = high-Z)
//   period_start_o       one-cycle pulse per period boundary
//   active_o             applied config awake and synced OE asserted
//
// Build option: PWM_OUTPUT_STAGE_BOUNDARY_LATCH_EN
//   defined   - MODE2 and SLEEP-clear are applied at period boundaries
//   undefined - applied-config registers reload every clock (2-clock config latency)
module pwm_output_stage #(
    parameter int unsigned CHANNELS    = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [11:0]         counter_i,
    input  logic [CHANNELS-1:0] pwm_i,
    input  logic [7:0]          mode2_i,
    input  logic                sleep_i,
    input  logic                oe_ni,
    output logic [CHANNELS-1:0] pwm_o,
    output logic [CHANNELS-1:0] pwm_oe_o,
    output logic                period_start_o,
    output logic                active_o
);

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned OUTNE_W = 2;

    logic [CNT_W-1:0]       prev_q, prev_d;
    logic                   invrt_q, invrt_d;
    logic                   outdrv_q, outdrv_d;
    logic [OUTNE_W-1:0]     outne_q, outne_d;
    logic                   sleep_q, sleep_d;
    logic [SYNC_STAGES-1:0] oe_sync_q, oe_sync_d;
    logic [CHANNELS-1:0]    pwm_q, pwm_d;
    logic [CHANNELS-1:0]    pwm_oe_q, pwm_oe_d;
    logic                   period_start_q, period_start_d;
    logic                   active_q, active_d;

    logic                   boundary_c;
    logic                   load_mode_c;
    logic                   oe_sync_c;
    logic [CHANNELS-1:0]    lvl_c;
    logic                   unused_mode2_c;

    // MODE2 bits that have no function in this block
    assign unused_mode2_c = ^{mode2_i[7:5], mode2_i[3]};

    // Period boundary: counter wraps to 0; a counter parked at 0 gives one boundary only
    always_comb begin
        prev_d         = counter_i;
        boundary_c     = (counter_i == CNT_W'(0)) && (prev_q != CNT_W'(0));
        period_start_d = boundary_c;
    end

    // Applied configuration update
    always_comb begin
        load_mode_c = 1'b0;
        sleep_d     = sleep_q;
`ifdef PWM_OUTPUT_STAGE_BOUNDARY_LATCH_EN
        // Going to sleep is immediate; waking waits for the boundary. While asleep the
        // pins are quiet, so MODE2 can follow the register without glitch risk.
        load_mode_c = boundary_c || sleep_q;
        if (sleep_i) begin
            sleep_d = 1'b1;
        end else if (boundary_c) begin
            sleep_d = 1'b0;
        end
`else
        load_mode_c = 1'b1;
        sleep_d     = sleep_i;
`endif
        invrt_d  = load_mode_c ? mode2_i[4]   : invrt_q;
        outdrv_d = load_mode_c ? mode2_i[2]   : outdrv_q;
        outne_d  = load_mode_c ? mode2_i[1:0] : outne_q;
    end

    // OE pin synchronizer; resets to the disabled level
    always_comb begin
        oe_sync_d = {oe_sync_q[SYNC_STAGES-2:0], oe_ni};
        oe_sync_c = oe_sync_q[SYNC_STAGES-1];
    end

    // Per-channel pin function
    always_comb begin
        pwm_d    = '0;
        pwm_oe_d = '0;
        lvl_c    = (sleep_q ? CHANNELS'(0) : pwm_i) ^ {CHANNELS{invrt_q}};
        if (!oe_sync_c) begin
            if (outdrv_q) begin
                pwm_d    = lvl_c;
                pwm_oe_d = '1;
            end else begin
                // Open-drain: drive low only, release for a high level
                pwm_d    = '0;
                pwm_oe_d = ~lvl_c;
            end
        end else begin
            unique case (outne_q)
                2'b00: begin
                    pwm_d    = '0;
                    pwm_oe_d = '1;
                end
                2'b01: begin
                    // Open-drain cannot drive a 1, so the pin floats in that mode
                    pwm_d    = '1;
                    pwm_oe_d = {CHANNELS{outdrv_q}};
                end
                default: begin
                    pwm_d    = '0;
                    pwm_oe_d = '0;
                end
            endcase
        end
        active_d = ~sleep_q & ~oe_sync_c;
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q         <= '0;
            invrt_q        <= 1'b0;
            outdrv_q       <= 1'b1;
            outne_q        <= '0;
            sleep_q        <= 1'b1;
            oe_sync_q      <= '1;
            pwm_q          <= '0;
            pwm_oe_q       <= '0;
            period_start_q <= 1'b0;
            active_q       <= 1'b0;
        end else begin
            prev_q         <= prev_d;
            invrt_q        <= invrt_d;
            outdrv_q       <= outdrv_d;
            outne_q        <= outne_d;
            sleep_q        <= sleep_d;
            oe_sync_q      <= oe_sync_d;
            pwm_q          <= pwm_d;
            pwm_oe_q       <= pwm_oe_d;
            period_start_q <= period_start_d;
            active_q       <= active_d;
        end
    end

    assign pwm_o          = pwm_q;
    assign pwm_oe_o       = pwm_oe_q;
    assign period_start_o = period_start_q;
    assign active_o       = active_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage: a vector table for reset/follow/wrap
// behaviour plus hand-written sequences for config, OE, open-drain and sleep.
module tb_pwm_output_stage;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] cnt   = '0;
    logic [15:0] pwm   = '0;
    logic [7:0]  mode2 = 8'h04;
    logic        sleep = 1'b1;
    logic        oe_n  = 1'b1;
    logic [15:0] pwm_o;
    logic [15:0] pwm_oe_o;
    logic        ps_o;
    logic        act_o;

    int n_total = 0;
    int n_pass  = 0;

    pwm_output_stage #(.CHANNELS(16), .SYNC_STAGES(2)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .counter_i      (cnt),
        .pwm_i          (pwm),
        .mode2_i        (mode2),
        .sleep_i        (sleep),
        .oe_ni          (oe_n),
        .pwm_o          (pwm_o),
        .pwm_oe_o       (pwm_oe_o),
        .period_start_o (ps_o),
        .active_o       (act_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] cnt;
        logic [15:0] pwm;
        logic [15:0] e_pwm;
        logic [15:0] e_oe;
        logic        e_ps;
        logic        e_act;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset spanning one clock, released on a falling edge
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cnt   = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reset then run until awake with OE synced and MODE2 = m applied
    task automatic wake(input logic [7:0] m);
        logic [11:0] seq [5];
        seq = '{12'd1, 12'd2, 12'd0, 12'd1, 12'd2};
        mode2 = m;
        sleep = 1'b0;
        oe_n  = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cnt = seq[i];
            step();
        end
    endtask

    vec_t tbl [15];

    initial begin
        logic [11:0] a_cnt [5];
        logic [15:0] a_pwm [5];
        logic        a_ps  [5];
        logic [7:0]  c_mode [5];
        logic [15:0] c_dis_pwm [5];
        logic [15:0] c_dis_oe  [5];
        logic [15:0] c_en_pwm  [5];
        logic [15:0] c_en_oe   [5];
        logic [11:0] d_cnt [6];
        logic        d_slp [6];
        logic [15:0] d_pwm [6];
        logic        d_act [6];
        logic        d_ps  [6];

        // Post-reset vectors: mode2=04, sleep_i=0, oe_n=0
        tbl[0]  = '{12'd5,    16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
        tbl[1]  = '{12'd6,    16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
`ifdef PWM_OUTPUT_STAGE_BOUNDARY_LATCH_EN
        tbl[2]  = '{12'd0,    16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, 1'b0};
`else
        tbl[2]  = '{12'd0,    16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1};
`endif
        tbl[3]  = '{12'd1,    16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1};
        tbl[4]  = '{12'd2,    16'h00F0, 16'h00F0, 16'hFFFF, 1'b0, 1'b1};
        tbl[5]  = '{12'd3,    16'h1234, 16'h1234, 16'hFFFF, 1'b0, 1'b1};
        tbl[6]  = '{12'd4095, 16'hAAAA, 16'hAAAA, 16'hFFFF, 1'b0, 1'b1};
        tbl[7]  = '{12'd0,    16'h5555, 16'h5555, 16'hFFFF, 1'b1, 1'b1};
        tbl[8]  = '{12'd0,    16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1};
        tbl[9]  = '{12'd0,    16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b1};
        tbl[10] = '{12'd0,    16'h8001, 16'h8001, 16'hFFFF, 1'b0, 1'b1};
        tbl[11] = '{12'd0,    16'h7FFE, 16'h7FFE, 16'hFFFF, 1'b0, 1'b1};
        tbl[12] = '{12'd1,    16'h0001, 16'h0001, 16'hFFFF, 1'b0, 1'b1};
        tbl[13] = '{12'd0,    16'h0F0F, 16'h0F0F, 16'hFFFF, 1'b1, 1'b1};
        tbl[14] = '{12'd7,    16'hF0F0, 16'hF0F0, 16'hFFFF, 1'b0, 1'b1};

        // Reset asserted with all channels high
        pwm = 16'hFFFF;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pwm",    pwm_o,    16'h0000);
        chk("rst_oe",     pwm_oe_o, 16'h0000);
        chk("rst_ps",     16'(ps_o),  16'h0);
        chk("rst_active", 16'(act_o), 16'h0);
        mode2 = 8'h04;
        sleep = 1'b0;
        oe_n  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            cnt = tbl[i].cnt;
            pwm = tbl[i].pwm;
            step();
            chk($sformatf("tbl%0d_pwm", i),    pwm_o,      tbl[i].e_pwm);
            chk($sformatf("tbl%0d_oe", i),     pwm_oe_o,   tbl[i].e_oe);
            chk($sformatf("tbl%0d_ps", i),     16'(ps_o),  16'(tbl[i].e_ps));
            chk($sformatf("tbl%0d_active", i), 16'(act_o), 16'(tbl[i].e_act));
        end

        // INVRT written mid-period
        pwm = 16'h0008;
        wake(8'h04);
        mode2 = 8'h14;
        a_cnt = '{12'd2000, 12'd2001, 12'd2002, 12'd0, 12'd1};
        a_ps  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef PWM_OUTPUT_STAGE_BOUNDARY_LATCH_EN
        a_pwm = '{16'h0008, 16'h0008, 16'h0008, 16'h0008, 16'hFFF7};
`else
        a_pwm = '{16'h0008, 16'hFFF7, 16'hFFF7, 16'hFFF7, 16'hFFF7};
`endif
        for (int i = 0; i < 5; i++) begin
            cnt = a_cnt[i];
            step();
            chk($sformatf("invrt%0d_pwm", i), pwm_o,     a_pwm[i]);
            chk($sformatf("invrt%0d_ps", i),  16'(ps_o), 16'(a_ps[i]));
        end

        // Open-drain with channel 0 toggling
        pwm = 16'h0000;
        wake(8'h00);
        for (int i = 0; i < 6; i++) begin
            pwm = (i % 3 == 1) ? 16'h0000 : 16'h0001;
            cnt = 12'(10 + i);
            step();
            chk($sformatf("od%0d_pwm", i), pwm_o,    16'h0000);
            chk($sformatf("od%0d_oe", i),  pwm_oe_o, ~pwm);
        end

        // OE pin pulse for each OUTNE value
        c_mode    = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h01};
        c_dis_pwm = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
        c_dis_oe  = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        c_en_pwm  = '{16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h0000};
        c_en_oe   = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFF00};
        pwm = 16'h00FF;
        for (int m = 0; m < 5; m++) begin
            wake(c_mode[m]);
            oe_n = 1'b1;
            cnt = 12'd3; step();
            cnt = 12'd4; step();
            chk($sformatf("oe%0d_hold_pwm", m), pwm_o,    c_en_pwm[m]);
            cnt = 12'd5; step();
            chk($sformatf("oe%0d_dis_pwm", m),  pwm_o,    c_dis_pwm[m]);
            chk($sformatf("oe%0d_dis_oe", m),   pwm_oe_o, c_dis_oe[m]);
            chk($sformatf("oe%0d_dis_act", m),  16'(act_o), 16'h0);
            oe_n = 1'b0;
            cnt = 12'd6; step();
            cnt = 12'd7; step();
            chk($sformatf("oe%0d_still_oe", m), pwm_oe_o, c_dis_oe[m]);
            cnt = 12'd8; step();
            chk($sformatf("oe%0d_en_pwm", m),   pwm_o,    c_en_pwm[m]);
            chk($sformatf("oe%0d_en_oe", m),    pwm_oe_o, c_en_oe[m]);
            chk($sformatf("oe%0d_en_act", m),   16'(act_o), 16'h1);
        end

        // Sleep mid-period, wake at counter 100
        pwm = 16'hFFFF;
        wake(8'h04);
        d_cnt = '{12'd50, 12'd51, 12'd100, 12'd101, 12'd0, 12'd1};
        d_slp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        d_ps  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef PWM_OUTPUT_STAGE_BOUNDARY_LATCH_EN
        d_pwm = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
        d_act = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        d_pwm = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        d_act = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 6; i++) begin
            cnt   = d_cnt[i];
            sleep = d_slp[i];
            step();
            chk($sformatf("sleep%0d_pwm", i), pwm_o,      d_pwm[i]);
            chk($sformatf("sleep%0d_act", i), 16'(act_o), 16'(d_act[i]));
            chk($sformatf("sleep%0d_ps", i),  16'(ps_o),  16'(d_ps[i]));
        end

        // Asynchronous reset mid-period clears outputs without a clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pwm", pwm_o,      16'h0000);
        chk("arst_oe",  pwm_oe_o,   16'h0000);
        chk("arst_act", 16'(act_o), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Counter parked at 0 through reset release: no boundary until it has been nonzero
        for (int i = 0; i < 3; i++) begin
            cnt = 12'd0;
            step();
            chk($sformatf("rel%0d_ps", i), 16'(ps_o), 16'h0);
        end
        cnt = 12'd1; step();
        chk("rel_nz_ps", 16'(ps_o), 16'h0);
        cnt = 12'd0; step();
        chk("rel_wrap_ps", 16'(ps_o), 16'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
